// File: rtl/reg_pipe_arst.sv
// Elastic pipeline register: DEPTH valid-tagged stages under valid/ready,
// with bubble collapsing, clock enable, synchronous clear and occupancy count.
module reg_pipe_arst #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                       real_clk,
    input  logic                       real_rst,
    input  logic                       ce,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] rdy;
    logic [CW-1:0]    count_q;
    logic             run;
    logic             in_xfer;
    logic             out_xfer;

    // Stage k may load when it or any stage after it is empty,
    // or when the consumer takes the last word.
    always_comb begin : ready_chain
        logic acc;
        rdy = '0;
        acc = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc    = acc | ~v_q[k];
            rdy[k] = acc;
        end
    end

    assign run       = ce & ~clr;
    assign in_ready  = run & rdy[0] & ~real_rst;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = v_q[DEPTH-1] & out_ready & run;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= INIT;
            end
            v_q     <= '0;
            count_q <= '0;
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= INIT;
            end
            v_q     <= '0;
            count_q <= '0;
        end else if (ce) begin
            if (rdy[0]) begin
                data_q[0] <= in_data;
                v_q[0]    <= in_valid;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    data_q[k] <= data_q[k-1];
                    v_q[k]    <= v_q[k-1];
                end
            end
            count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_reg_pipe_arst.sv
// Directed bench for reg_pipe_arst: word-position model checked every
// cycle, plus literal expectations along the test sequence.
module tb_reg_pipe_arst;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] INIT  = 8'hC3;

    logic       real_clk = 1'b0;
    logic       real_rst;
    logic       ce;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int checks   = 0;
    int failures = 0;

    reg_pipe_arst #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
        .real_clk (real_clk),
        .real_rst (real_rst),
        .ce       (ce),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 real_clk = ~real_clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: words held oldest-first with their stage position.
    logic [7:0] mq_data[$];
    int         mq_pos[$];

    function automatic bit model_r0(input logic ordy);
        bit mv;
        int n;
        mv = 1'b0;
        n  = mq_pos.size();
        if (n == 0) return 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == 0) mv = (mq_pos[0] == DEPTH - 1) ? ordy : 1'b1;
            else mv = (mq_pos[i-1] != mq_pos[i] + 1) || mv;
        end
        return (mq_pos[n-1] != 0) || mv;
    endfunction

    always @(posedge real_clk or posedge real_rst) begin
        if (real_rst || clr) begin
            mq_data.delete();
            mq_pos.delete();
        end else if (ce) begin
            bit mv [DEPTH];
            bit r0;
            int n;
            n  = mq_pos.size();
            r0 = model_r0(out_ready);
            for (int i = 0; i < n; i++) begin
                if (i == 0) mv[i] = (mq_pos[0] == DEPTH - 1) ? out_ready : 1'b1;
                else mv[i] = (mq_pos[i-1] != mq_pos[i] + 1) || mv[i-1];
            end
            for (int i = 0; i < n; i++)
                if (mv[i]) mq_pos[i] = mq_pos[i] + 1;
            if (n > 0 && mq_pos[0] == DEPTH) begin
                void'(mq_pos.pop_front());
                void'(mq_data.pop_front());
            end
            if (in_valid && r0) begin
                mq_data.push_back(in_data);
                mq_pos.push_back(0);
            end
        end
    end

    always @(negedge real_clk) begin
        bit ev;
        ev = (mq_pos.size() > 0) && (mq_pos[0] == DEPTH - 1);
        chk("m_out_valid", 32'(out_valid), 32'(ev));
        if (ev) chk("m_out_data", 32'(out_data), 32'(mq_data[0]));
        chk("m_count", 32'(count), 32'(mq_pos.size()));
        chk("m_in_ready", 32'(in_ready),
            32'(ce & ~clr & ~real_rst & model_r0(out_ready)));
    end

    task automatic tick();
        @(posedge real_clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic expect_out(input string nm, input logic v,
                              input logic [7:0] d, input int c);
        chk({nm, "_valid"}, 32'(out_valid), 32'(v));
        if (v) chk({nm, "_data"}, 32'(out_data), 32'(d));
        chk({nm, "_count"}, 32'(count), 32'(c));
    endtask

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        real_rst  = 1'b1;
        ce        = 1'b1;
        clr       = 1'b0;
        out_ready = 1'b1;
        put(1'b0, INIT);
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'(INIT));
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        real_rst = 1'b0;
        tick();

        // Streaming 11..44 with out_ready high
        put(1'b1, 8'h11); tick();
        put(1'b1, 8'h22); tick();
        put(1'b1, 8'h33); tick();
        expect_out("st0", 1'b1, 8'h11, 3);
        put(1'b1, 8'h44); tick();
        expect_out("st1", 1'b1, 8'h22, 3);
        put(1'b0, INIT); tick();
        expect_out("st2", 1'b1, 8'h33, 2);
        tick();
        expect_out("st3", 1'b1, 8'h44, 1);
        tick();
        expect_out("st4", 1'b0, 8'h00, 0);

        // Backpressure with a bubble that must collapse
        out_ready = 1'b0;
        put(1'b1, 8'hA1); tick();
        put(1'b0, INIT);  tick();
        put(1'b1, 8'hA2); tick();
        put(1'b1, 8'hA3); tick();
        expect_out("bp_full", 1'b1, 8'hA1, 3);
        put(1'b1, 8'hA4);
        #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        expect_out("bp_hold", 1'b1, 8'hA1, 3);
        put(1'b0, INIT);
        out_ready = 1'b1;
        tick();
        expect_out("bp_a2", 1'b1, 8'hA2, 2);
        tick();
        expect_out("bp_a3", 1'b1, 8'hA3, 1);
        tick();
        expect_out("bp_end", 1'b0, 8'h00, 0);

        // Full pass-through
        out_ready = 1'b0;
        put(1'b1, 8'h61); tick();
        put(1'b1, 8'h62); tick();
        put(1'b1, 8'h63); tick();
        out_ready = 1'b1;
        put(1'b1, 8'h55);
        #1 chk("pt_in_ready", 32'(in_ready), 32'd1);
        tick();
        expect_out("pt0", 1'b1, 8'h62, 3);
        put(1'b0, INIT); tick();
        expect_out("pt1", 1'b1, 8'h63, 2);
        tick();
        expect_out("pt2", 1'b1, 8'h55, 1);
        tick();
        expect_out("pt3", 1'b0, 8'h00, 0);

        // Clock enable low mid-stream
        put(1'b1, 8'hB1); tick();
        put(1'b1, 8'hB2); tick();
        put(1'b1, 8'hB3); tick();
        ce = 1'b0;
        put(1'b1, 8'hB4);
        #1 chk("ce_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("ce_hold", 1'b1, 8'hB1, 3);
        end
        ce = 1'b1;
        tick();
        expect_out("ce_b2", 1'b1, 8'hB2, 3);
        put(1'b0, INIT); tick();
        expect_out("ce_b3", 1'b1, 8'hB3, 2);
        tick();
        expect_out("ce_b4", 1'b1, 8'hB4, 1);
        tick();
        expect_out("ce_end", 1'b0, 8'h00, 0);

        // Synchronous clear with a word at the output
        out_ready = 1'b0;
        put(1'b1, 8'hC1); tick();
        put(1'b1, 8'hC2); tick();
        put(1'b0, INIT);  tick();
        expect_out("clr_pre", 1'b1, 8'hC1, 2);
        clr       = 1'b1;
        out_ready = 1'b1;
        put(1'b1, 8'hCC);
        #1 chk("clr_in_ready", 32'(in_ready), 32'd0);
        tick();
        clr = 1'b0;
        put(1'b0, INIT);
        expect_out("clr_post", 1'b0, 8'h00, 0);
        chk("clr_out_data", 32'(out_data), 32'(INIT));
        tick(); tick(); tick();
        expect_out("clr_idle", 1'b0, 8'h00, 0);

        // Async reset with two words in flight
        put(1'b1, 8'hD1); tick();
        put(1'b1, 8'hD2); tick();
        put(1'b0, INIT);
        chk("ar_pre_count", 32'(count), 32'd2);
        #1 real_rst = 1'b1;
        #1;
        expect_out("ar_now", 1'b0, 8'h00, 0);
        chk("ar_out_data", 32'(out_data), 32'(INIT));
        chk("ar_in_ready", 32'(in_ready), 32'd0);
        tick();
        real_rst = 1'b0;
        tick(); tick(); tick(); tick();
        expect_out("ar_after", 1'b0, 8'h00, 0);
        chk("ar_after_data", 32'(out_data), 32'(INIT));

        // First accept right after reset release
        put(1'b1, 8'hE1); tick();
        put(1'b0, INIT); tick(); tick();
        expect_out("ar_first", 1'b1, 8'hE1, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
